// File: rtl/fan_pkg.sv
// Shared types and default widths for the fan PWM controller.
package fan_pkg;

  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned STEP_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2
  } fan_state_t;

endpackage

// File: rtl/pwm_counter.sv
// Period counter with boundary detect and registered duty compare.
module pwm_counter import fan_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             pwm_en,
  input  logic [CNT_W-1:0] per_a,
  input  logic [CNT_W-1:0] duty_cur,
  output logic             boundary,
  output logic             pwm
);

  logic [CNT_W-1:0] cnt;

  assign boundary = run && (cnt == per_a);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      if (!run || boundary) cnt <= '0;
      else                  cnt <= cnt + 1'b1;
      // pwm_en looks at the next state so the output is already low in the first IDLE cycle
      pwm <= pwm_en && (cnt < duty_cur);
    end
  end

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Fan PWM controller: shadowed config, boundary-aligned reload and duty ramping.
module fan_pwm_ctrl import fan_pkg::*; #(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned STEP_W = STEP_W_DEF
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic              cfg_enable,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_duty,
  input  logic [STEP_W-1:0] cfg_ramp_step,
  input  logic              cfg_update,
  output logic              fan_pwm,
  output logic              period_tick,
  output logic [CNT_W-1:0]  duty_cur,
  output logic              ramping
);

  fan_state_t        state, state_next;
  logic [CNT_W-1:0]  sh_per, sh_duty, per_a, tgt_a;
  logic [STEP_W-1:0] sh_step, step_a;
  logic [CNT_W-1:0]  duty_next, ramp_next;
  logic [CNT_W:0]    step_x, up_sum, dn_gap;
  logic              load_act, boundary, run, pwm_en;

  assign run         = (state != IDLE);
  assign pwm_en      = (state_next != IDLE);
  assign period_tick = boundary;
  assign ramping     = (state == RAMP);

  pwm_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (axi_aclk),
    .rst      (axi_areset),
    .run      (run),
    .pwm_en   (pwm_en),
    .per_a    (per_a),
    .duty_cur (duty_cur),
    .boundary (boundary),
    .pwm      (fan_pwm)
  );

  // One extra bit keeps the sum and the gap free of wrap-around
  always_comb begin
    step_x    = (CNT_W+1)'(step_a);
    up_sum    = {1'b0, duty_cur} + step_x;
    dn_gap    = {1'b0, duty_cur} - {1'b0, tgt_a};
    ramp_next = tgt_a;
    if (step_a != '0) begin
      if (duty_cur < tgt_a) begin
        if (up_sum < {1'b0, tgt_a}) ramp_next = up_sum[CNT_W-1:0];
      end else if (dn_gap > step_x) begin
        ramp_next = duty_cur - step_x[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    state_next = state;
    duty_next  = duty_cur;
    load_act   = 1'b0;
    unique case (state)
      IDLE: begin
        duty_next = '0;
        if (cfg_enable) begin
          load_act   = 1'b1;
          state_next = RAMP;
        end
      end
      RAMP, RUN: begin
        if (boundary) begin
          load_act = 1'b1;
          if (!cfg_enable) begin
            duty_next  = '0;
            state_next = IDLE;
          end else begin
            if (state == RAMP) duty_next = ramp_next;
            // compare against the target being loaded at this same edge
            state_next = (duty_next == sh_duty) ? RUN : RAMP;
          end
        end
      end
      default: begin
        duty_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= IDLE;
      duty_cur <= '0;
      sh_per   <= '0;
      sh_duty  <= '0;
      sh_step  <= '0;
      per_a    <= '0;
      tgt_a    <= '0;
      step_a   <= '0;
    end else begin
      state    <= state_next;
      duty_cur <= duty_next;
      if (cfg_update) begin
        sh_per  <= cfg_period;
        sh_duty <= cfg_duty;
        sh_step <= cfg_ramp_step;
      end
      if (load_act) begin
        per_a  <= sh_per;
        tgt_a  <= sh_duty;
        step_a <= sh_step;
      end
    end
  end

endmodule

// File: doc/fan_pwm_ctrl.md
FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the period/duty counters.
REQ-002 Parameter STEP_W, default 8, width of the ramp step.
REQ-003 axi_aclk  in  1  sole clock; all state SHALL be clocked on its rising edge.
REQ-004 axi_areset  in  1  asynchronous, active-high reset.
REQ-005 cfg_enable  in  1  level; 1 = fan drive permitted.
REQ-006 cfg_period  in  CNT_W  PWM period minus one, in clocks.
REQ-007 cfg_duty  in  CNT_W  target high-time, in clocks.
REQ-008 cfg_ramp_step  in  STEP_W  duty change per period while ramping; 0 = jump.
REQ-009 cfg_update  in  1  one-cycle strobe; latch cfg_period/cfg_duty/cfg_ramp_step into shadow registers.
REQ-010 fan_pwm  out  1  registered PWM output.
REQ-011 period_tick  out  1  one-cycle pulse on the last count of each period.
REQ-012 duty_cur  out  CNT_W  duty value currently applied, for register readback.
REQ-013 ramping  out  1  high while state is RAMP.

Function
REQ-014 Period counter cnt SHALL count 0..per_a (active period), wrapping to 0; boundary = (cnt == per_a).
REQ-015 period_tick SHALL be 1 exactly in the boundary cycle.
REQ-016 fan_pwm SHALL equal the registered value of (cnt < duty_cur) with one clock of latency, and SHALL be 0 in state IDLE.
REQ-017 duty_cur >= per_a+1 SHALL give constant high; duty_cur = 0 SHALL give constant low.
REQ-018 cfg_update SHALL load the shadows on the next edge; a cfg_update with no boundary pending SHALL overwrite the earlier shadow values (last write wins).
REQ-019 Active registers (per_a, duty target tgt_a, step_a) SHALL copy the shadows only at a boundary, using the shadow values held before that edge.
REQ-020 A cfg_update coincident with a boundary SHALL take effect at the following boundary.
REQ-021 A period change SHALL never truncate or extend the period in progress.
REQ-022 States: IDLE, RAMP, RUN.
REQ-023 IDLE: cnt held at 0, duty_cur = 0; when cfg_enable = 1, load the active registers from the shadows and go to RAMP on the next edge.
REQ-024 RAMP: at each boundary, if duty_cur < tgt_a, duty_cur = min(duty_cur+step_a, tgt_a); if duty_cur > tgt_a, duty_cur = max(duty_cur-step_a, tgt_a); the arithmetic SHALL be CNT_W+1 bits wide, with no wrap-around.
REQ-025 step_a = 0 in RAMP SHALL set duty_cur = tgt_a at the next boundary.
REQ-026 RAMP -> RUN when duty_cur == tgt_a after an update; RUN -> RAMP when a boundary loads tgt_a != duty_cur.
REQ-027 cfg_enable = 0 in RAMP or RUN SHALL, at the next boundary, clear duty_cur and go to IDLE; the current period SHALL complete unchanged.
REQ-028 per_a = 0 SHALL make every cycle a boundary, with output constant per REQ-017.

Reset
REQ-029 Asserting axi_areset SHALL immediately force: state IDLE, cnt 0, duty_cur 0, all shadows and active registers 0, fan_pwm 0, period_tick 0, ramping 0.
REQ-030 Reset asserted mid-period or mid-ramp SHALL discard all progress; after deassertion the block SHALL stay in IDLE until cfg_enable = 1.

Structure
REQ-031 Shared package fan_pkg SHALL hold the state enum type and the CNT_W/STEP_W defaults.
REQ-032 One sub-module, pwm_counter (cnt, boundary detect, compare register), SHALL be instantiated; the state machine, shadow and ramp logic SHALL remain in fan_pwm_ctrl.

Verification
REQ-033 Setup: period 9, duty 4, step 0, update, enable -> from the second period on, fan_pwm is high 4 of every 10 cycles and period_tick occurs every 10 cycles.
REQ-034 Ramp up: period 99, duty 50, step 20 -> duty_cur goes 20, 40, 50 at successive boundaries; ramping drops after 50.
REQ-035 Ramp down from RUN at 50: update duty 5, step 20 -> duty_cur goes 30, 10, 5, then RUN.
REQ-036 Period 9 -> 3 written mid-period -> the current period lasts 10 cycles and the next lasts 4; an update on the boundary cycle applies one period later.
REQ-037 Duty 200 with period 99 -> fan_pwm constant high; disable -> the period completes, then fan_pwm is 0 and state is IDLE.
REQ-038 axi_areset pulsed mid-ramp -> all outputs read 0 in the same cycle; after release, cfg_enable = 1 with the shadows still 0 -> fan_pwm stays 0.
